// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_pkg : shared types and helpers for the UART transmitter            |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Phase increment rounded to nearest: round(baud * 2^acc_w / clk_hz).
  function automatic longint unsigned baud_inc(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input int unsigned     acc_w
  );
    return ((baud << acc_w) + (clk_hz >> 1)) / clk_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_sync_fifo : DEPTH x DATA_W synchronous FIFO, registered pointers   |
// | Revision       : 1.0                                                    |
// +------------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        wrData,
  input  logic                     wrEn,
  input  logic                     rdEn,
  output logic [DATA_W-1:0]        rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_ptrW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_ptrW:0]   r_wrPtr;
  logic [c_ptrW:0]   r_rdPtr;
  logic              w_push;
  logic              w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level  = r_wrPtr - r_rdPtr;
  assign full   = (level == (c_ptrW+1)'(DEPTH));
  assign empty  = (r_wrPtr == r_rdPtr);
  assign w_push = wrEn & ~full;
  assign w_pop  = rdEn & ~empty;
  assign rdData = r_mem[r_rdPtr[c_ptrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + (c_ptrW+1)'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + (c_ptrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr[c_ptrW-1:0]] <= wrData;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_tx_fifo : FIFO-fed UART transmitter, DATA_W bits, 1/2 stop bits    |
// |                optional parity generator under UART_TX_PARITY_EN        |
// | Revision     : 1.0                                                      |
// +------------------------------------------------------------------------+
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115_200,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ACC_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             cfg_parity,
  input  logic                   cfg_stop2,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   txd
);

  if (CLK_HZ < 8 * BAUD) begin : g_badBaud
    $error("uart_tx_fifo: CLK_HZ must be at least 8*BAUD");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_badDataW
    $error("uart_tx_fifo: DATA_W must be in 5..9");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  localparam longint unsigned c_incFull = baud_inc(longint'(CLK_HZ), longint'(BAUD), ACC_W);
  localparam logic [ACC_W:0]  c_inc     = (ACC_W+1)'(c_incFull);
  localparam int              c_cntW    = $clog2(DATA_W);
  localparam logic [c_cntW-1:0] c_lastBit = c_cntW'(DATA_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_stateNext;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W:0]    w_accSum;
  logic              w_tick;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shiftNext;
  logic [DATA_W-1:0] w_fifoData;
  logic [c_cntW-1:0] r_bitCnt;
  logic              r_stop2;
  logic              r_stopCnt;
  logic              r_txd;
  logic              w_txdNext;
  logic              w_pop;
  logic              w_fifoFull;
  logic              w_fifoEmpty;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrData (in_data),
    .wrEn   (in_valid),
    .rdEn   (w_pop),
    .rdData (w_fifoData),
    .full   (w_fifoFull),
    .empty  (w_fifoEmpty),
    .level  (fifo_level)
  );

  assign w_accSum = {1'b0, r_acc} + c_inc;
  assign w_tick   = w_accSum[ACC_W];

`ifdef UART_TX_PARITY_EN
  logic r_parEn;
  logic r_parBit;

  // Parity is fixed from the word at pop time so later cfg changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parEn  <= 1'b0;
      r_parBit <= 1'b0;
    end else if (w_pop) begin
      r_parEn  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      r_parBit <= (cfg_parity == PAR_ODD) ? ~^w_fifoData : ^w_fifoData;
    end
  end
`else
  logic w_unusedCfgParity;
  assign w_unusedCfgParity = ^cfg_parity;
`endif

  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_shiftNext = r_shift;
    w_txdNext   = 1'b1;
    case (r_state)
      IDLE: begin
        if (!w_fifoEmpty) begin
          w_pop       = 1'b1;
          w_shiftNext = w_fifoData;
          w_stateNext = START;
        end
      end
      START: if (w_tick) w_stateNext = DATA;
      DATA: begin
        if (w_tick) begin
          w_shiftNext = r_shift >> 1;
          if (r_bitCnt == c_lastBit) begin
            w_stateNext = STOP;
`ifdef UART_TX_PARITY_EN
            if (r_parEn) w_stateNext = PARITY;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_tick) w_stateNext = STOP;
`endif
      STOP: begin
        if (w_tick && !(r_stop2 && !r_stopCnt)) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase

    // Line level is derived from the upcoming state so txd leaves a flop.
    case (w_stateNext)
      START:   w_txdNext = 1'b0;
      DATA:    w_txdNext = w_shiftNext[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_txdNext = r_parBit;
`endif
      default: w_txdNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_shift   <= '0;
      r_bitCnt  <= '0;
      r_stop2   <= 1'b0;
      r_stopCnt <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      r_txd   <= w_txdNext;
      r_shift <= w_shiftNext;
      r_acc   <= (r_state == IDLE) ? '0 : w_accSum[ACC_W-1:0];
      if (w_pop) begin
        r_bitCnt  <= '0;
        r_stop2   <= cfg_stop2;
        r_stopCnt <= 1'b0;
      end else begin
        if (r_state == DATA && w_tick) r_bitCnt  <= r_bitCnt + c_cntW'(1);
        if (r_state == STOP && w_tick) r_stopCnt <= 1'b1;
      end
    end
  end

  assign txd      = r_txd;
  assign in_ready = ~w_fifoFull;
  assign busy     = (r_state != IDLE) | (fifo_level != '0);

endmodule
`default_nettype wire
